urv_dbus_arbiter: RTL and testbench

URV_DBUS_ARBITER -- requirements
Module: urv_dbus_arbiter

---
 rtl/urv_dbus_arbiter_pkg.sv | 32 +++
 rtl/urv_dbus_port.sv | 56 +++++
 rtl/urv_dbus_arbiter.sv | 123 ++++++++++++
 tb/tb_urv_dbus_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/urv_dbus_arbiter_pkg.sv
// Shared AHB-Lite encodings, port indices and pending-request record for the
// two-master data-bus arbiter.
package urv_dbus_arbiter_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

  localparam logic PORT_CORE  = 1'b0;
  localparam logic PORT_DEBUG = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic        valid;
  } pend_t;

  // SEQ carries no burst meaning here; both count as a fresh single transfer.
  function automatic logic htrans_active(input logic [1:0] t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/urv_dbus_port.sv
// Per-master front end: one-entry request buffer plus the outstanding-transfer
// flag that decides when this master is allowed to see HREADY.
module urv_dbus_port
  import urv_dbus_arbiter_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic        dp_done,
  input  logic        grant,
  output logic        hready,
  output logic        req,
  output pend_t       pend
);

  logic        out_q;
  logic        valid_q;
  logic [31:0] addr_q;
  logic        write_q;
  logic [2:0]  size_q;
  logic        live_req;

  assign hready   = out_q ? dp_done : 1'b1;
  assign live_req = htrans_active(htrans) && hready;
  assign req      = valid_q || live_req;

  assign pend.addr  = addr_q;
  assign pend.write = write_q;
  assign pend.size  = size_q;
  assign pend.valid = valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      if (live_req)     out_q <= 1'b1;
      else if (dp_done) out_q <= 1'b0;
      if (grant)         valid_q <= 1'b0;
      else if (live_req) valid_q <= 1'b1;
    end
  end

  // Buffer payload needs no reset: it is only looked at while valid_q is set.
  always_ff @(posedge clk_i) begin
    if (live_req && !grant) begin
      addr_q  <= haddr;
      write_q <= hwrite;
      size_q  <= hsize;
    end
  end

endmodule

// File: rtl/urv_dbus_arbiter.sv
// Two-master (core, debug) AHB-Lite data-bus arbiter onto a single slave port.
// Define URV_DBUS_RR_EN for round-robin arbitration; default is core-first.
module urv_dbus_arbiter
  import urv_dbus_arbiter_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] m0_haddr,
  input  logic [1:0]  m0_htrans,
  input  logic        m0_hwrite,
  input  logic [2:0]  m0_hsize,
  input  logic [31:0] m0_hwdata,
  output logic        m0_hready_o,
  output logic [31:0] m0_hrdata_o,
  output logic        m0_hresp_o,
  input  logic [31:0] m1_haddr,
  input  logic [1:0]  m1_htrans,
  input  logic        m1_hwrite,
  input  logic [2:0]  m1_hsize,
  input  logic [31:0] m1_hwdata,
  output logic        m1_hready_o,
  output logic [31:0] m1_hrdata_o,
  output logic        m1_hresp_o,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [3:0]  HPROT,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  input  logic        HRESP
);

  logic [1:0] req;
  logic [1:0] grant;
  logic [1:0] dp_done;
  pend_t      pend0;
  pend_t      pend1;
  logic       dp_valid;
  logic       dp_owner;

  assign dp_done[PORT_CORE]  = dp_valid && (dp_owner == PORT_CORE)  && HREADY;
  assign dp_done[PORT_DEBUG] = dp_valid && (dp_owner == PORT_DEBUG) && HREADY;

  urv_dbus_port u_port0 (
    .clk_i(clk_i), .rst_i(rst_i),
    .haddr(m0_haddr), .htrans(m0_htrans), .hwrite(m0_hwrite), .hsize(m0_hsize),
    .dp_done(dp_done[PORT_CORE]), .grant(grant[PORT_CORE]),
    .hready(m0_hready_o), .req(req[PORT_CORE]), .pend(pend0)
  );

  urv_dbus_port u_port1 (
    .clk_i(clk_i), .rst_i(rst_i),
    .haddr(m1_haddr), .htrans(m1_htrans), .hwrite(m1_hwrite), .hsize(m1_hsize),
    .dp_done(dp_done[PORT_DEBUG]), .grant(grant[PORT_DEBUG]),
    .hready(m1_hready_o), .req(req[PORT_DEBUG]), .pend(pend1)
  );

`ifdef URV_DBUS_RR_EN
  logic last_grant;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       last_grant <= PORT_CORE;
    else if (|grant) last_grant <= grant[PORT_DEBUG];
  end
`endif

  // Address phase: the slave can only take a new address while HREADY is high.
  always_comb begin
    grant = 2'b00;
    if (HREADY && !rst_i) begin
`ifdef URV_DBUS_RR_EN
      if (&req) grant = (last_grant == PORT_CORE) ? 2'b10 : 2'b01;
      else      grant = req;
`else
      if (req[PORT_CORE])       grant = 2'b01;
      else if (req[PORT_DEBUG]) grant = 2'b10;
`endif
    end
  end

  always_comb begin
    HTRANS = HTRANS_IDLE;
    HADDR  = '0;
    HWRITE = 1'b0;
    HSIZE  = '0;
    if (grant[PORT_DEBUG]) begin
      HTRANS = HTRANS_NONSEQ;
      if (pend1.valid) {HADDR, HWRITE, HSIZE} = {pend1.addr, pend1.write, pend1.size};
      else             {HADDR, HWRITE, HSIZE} = {m1_haddr, m1_hwrite, m1_hsize};
    end else if (grant[PORT_CORE]) begin
      HTRANS = HTRANS_NONSEQ;
      if (pend0.valid) {HADDR, HWRITE, HSIZE} = {pend0.addr, pend0.write, pend0.size};
      else             {HADDR, HWRITE, HSIZE} = {m0_haddr, m0_hwrite, m0_hsize};
    end
  end

  // Data phase: tracks whose transfer the slave is currently serving.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dp_valid <= 1'b0;
      dp_owner <= PORT_CORE;
    end else if (HREADY) begin
      dp_valid <= |grant;
      if (|grant) dp_owner <= grant[PORT_DEBUG];
    end
  end

  assign HWDATA = !dp_valid ? '0 : (dp_owner == PORT_DEBUG) ? m1_hwdata : m0_hwdata;

  assign m0_hrdata_o = HRDATA;
  assign m1_hrdata_o = HRDATA;
  assign m0_hresp_o  = dp_valid && (dp_owner == PORT_CORE)  && HRESP;
  assign m1_hresp_o  = dp_valid && (dp_owner == PORT_DEBUG) && HRESP;

  assign HBURST    = HBURST_SINGLE;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = HPROT_DATA_PRIV;

endmodule

// File: tb/tb_urv_dbus_arbiter.sv
// Bench for urv_dbus_arbiter: directed bus scenarios plus randomized traffic
// checked against a transaction-level master/slave model.
module tb_urv_dbus_arbiter;
  import urv_dbus_arbiter_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [1:0][31:0] m_haddr;
  logic [1:0][1:0]  m_htrans;
  logic [1:0]       m_hwrite;
  logic [1:0][2:0]  m_hsize;
  logic [1:0][31:0] m_hwdata;
  logic [1:0]       m_hready_o;
  logic [1:0][31:0] m_hrdata_o;
  logic [1:0]       m_hresp_o;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  int n_tests = 0;
  int n_fail  = 0;

  urv_dbus_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_haddr(m_haddr[0]), .m0_htrans(m_htrans[0]), .m0_hwrite(m_hwrite[0]),
    .m0_hsize(m_hsize[0]), .m0_hwdata(m_hwdata[0]),
    .m0_hready_o(m_hready_o[0]), .m0_hrdata_o(m_hrdata_o[0]), .m0_hresp_o(m_hresp_o[0]),
    .m1_haddr(m_haddr[1]), .m1_htrans(m_htrans[1]), .m1_hwrite(m_hwrite[1]),
    .m1_hsize(m_hsize[1]), .m1_hwdata(m_hwdata[1]),
    .m1_hready_o(m_hready_o[1]), .m1_hrdata_o(m_hrdata_o[1]), .m1_hresp_o(m_hresp_o[1]),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [1:0]  trans;
    logic        port;
  } txn_t;

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5a5a_0000;
  endfunction

  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      m_haddr[k] = '0; m_htrans[k] = HTRANS_IDLE; m_hwrite[k] = 1'b0;
      m_hsize[k] = HSIZE_WORD; m_hwdata[k] = '0;
    end
    HREADY = 1'b1; HRDATA = '0; HRESP = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1'b1;
    m_htrans[1] = HTRANS_NONSEQ; m_haddr[1] = 32'h0000_0abc; HRESP = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    n_tests++; if (HTRANS !== HTRANS_IDLE) begin n_fail++; $display("FAIL reset_htrans: got %b want 00", HTRANS); end
    n_tests++; if (HADDR !== 32'h0) begin n_fail++; $display("FAIL reset_haddr: got %h want 0", HADDR); end
    n_tests++; if (m_hready_o !== 2'b11) begin n_fail++; $display("FAIL reset_hready: got %b want 11", m_hready_o); end
    n_tests++; if (m_hresp_o !== 2'b00) begin n_fail++; $display("FAIL reset_hresp: got %b want 00", m_hresp_o); end
    n_tests++; if (HBURST !== 3'b000 || HMASTLOCK !== 1'b0) begin n_fail++; $display("FAIL reset_burst_lock: got %b/%b want 000/0", HBURST, HMASTLOCK); end
    n_tests++; if (HPROT !== 4'b0011) begin n_fail++; $display("FAIL reset_hprot: got %b want 0011", HPROT); end
    next_cycle();
    rst_i = 1'b0;
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_single_read();
    idle_inputs();
    m_htrans[0] = HTRANS_NONSEQ; m_haddr[0] = 32'h1000; m_hsize[0] = HSIZE_WORD;
    @(negedge clk_i);
    n_tests++; if (HTRANS !== HTRANS_NONSEQ) begin n_fail++; $display("FAIL rd_htrans: got %b want 10", HTRANS); end
    n_tests++; if (HADDR !== 32'h1000 || HWRITE !== 1'b0 || HSIZE !== HSIZE_WORD) begin n_fail++; $display("FAIL rd_addr: got %h/%b/%h want 1000/0/2", HADDR, HWRITE, HSIZE); end
    next_cycle();
    m_htrans[0] = HTRANS_IDLE; HRDATA = 32'h1234_5678;
    @(negedge clk_i);
    n_tests++; if (m_hready_o[0] !== 1'b1) begin n_fail++; $display("FAIL rd_hready: got %b want 1", m_hready_o[0]); end
    n_tests++; if (m_hrdata_o[0] !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_hrdata: got %h want 12345678", m_hrdata_o[0]); end
    n_tests++; if (HTRANS !== HTRANS_IDLE) begin n_fail++; $display("FAIL rd_idle: got %b want 00", HTRANS); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_conflict();
    idle_inputs();
    m_htrans[0] = HTRANS_NONSEQ; m_haddr[0] = 32'h2000;
    m_htrans[1] = HTRANS_NONSEQ; m_haddr[1] = 32'h3000;
    @(negedge clk_i);
    n_tests++; if (HADDR !== 32'h2000 || HTRANS !== HTRANS_NONSEQ) begin n_fail++; $display("FAIL cf_first: got %h/%b want 2000/10", HADDR, HTRANS); end
    n_tests++; if (m_hready_o[1] !== 1'b1) begin n_fail++; $display("FAIL cf_m1_accept: got %b want 1", m_hready_o[1]); end
    next_cycle();
    m_htrans[0] = HTRANS_IDLE; m_htrans[1] = HTRANS_IDLE;
    @(negedge clk_i);
    n_tests++; if (HADDR !== 32'h3000 || HTRANS !== HTRANS_NONSEQ) begin n_fail++; $display("FAIL cf_second: got %h/%b want 3000/10", HADDR, HTRANS); end
    n_tests++; if (m_hready_o !== 2'b01) begin n_fail++; $display("FAIL cf_hready_mid: got %b want 01", m_hready_o); end
    next_cycle();
    HRDATA = 32'hcafe_f00d;
    @(negedge clk_i);
    n_tests++; if (m_hready_o[1] !== 1'b1 || m_hrdata_o[1] !== 32'hcafe_f00d) begin n_fail++; $display("FAIL cf_m1_data: got %b/%h want 1/cafef00d", m_hready_o[1], m_hrdata_o[1]); end
    n_tests++; if (HTRANS !== HTRANS_IDLE) begin n_fail++; $display("FAIL cf_idle: got %b want 00", HTRANS); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_write_wait();
    idle_inputs();
    m_htrans[1] = HTRANS_NONSEQ; m_haddr[1] = 32'h4000; m_hwrite[1] = 1'b1;
    @(negedge clk_i);
    n_tests++; if (HADDR !== 32'h4000 || HWRITE !== 1'b1) begin n_fail++; $display("FAIL wr_addr: got %h/%b want 4000/1", HADDR, HWRITE); end
    next_cycle();
    m_htrans[1] = HTRANS_IDLE; m_hwrite[1] = 1'b0; m_hwdata[1] = 32'hdead_beef;
    m_hwdata[0] = 32'h1111_2222;
    for (int i = 0; i < 3; i++) begin
      HREADY = (i == 2);
      @(negedge clk_i);
      n_tests++; if (HWDATA !== 32'hdead_beef) begin n_fail++; $display("FAIL wr_hwdata[%0d]: got %h want deadbeef", i, HWDATA); end
      n_tests++; if (m_hready_o[1] !== (i == 2)) begin n_fail++; $display("FAIL wr_hready[%0d]: got %b want %b", i, m_hready_o[1], (i == 2)); end
      next_cycle();
    end
    HREADY = 1'b1;
    @(negedge clk_i);
    n_tests++; if (HWDATA !== 32'h0) begin n_fail++; $display("FAIL wr_hwdata_after: got %h want 0", HWDATA); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_wait_buffer();
    idle_inputs();
    HREADY = 1'b0;
    m_htrans[0] = HTRANS_NONSEQ; m_haddr[0] = 32'h5000;
    @(negedge clk_i);
    n_tests++; if (HTRANS !== HTRANS_IDLE || HADDR !== 32'h0) begin n_fail++; $display("FAIL wb_hold: got %b/%h want 00/0", HTRANS, HADDR); end
    n_tests++; if (m_hready_o[0] !== 1'b1) begin n_fail++; $display("FAIL wb_accept: got %b want 1", m_hready_o[0]); end
    next_cycle();
    m_htrans[0] = HTRANS_IDLE;
    @(negedge clk_i);
    n_tests++; if (HTRANS !== HTRANS_IDLE || m_hready_o[0] !== 1'b0) begin n_fail++; $display("FAIL wb_wait: got %b/%b want 00/0", HTRANS, m_hready_o[0]); end
    next_cycle();
    HREADY = 1'b1;
    @(negedge clk_i);
    n_tests++; if (HTRANS !== HTRANS_NONSEQ || HADDR !== 32'h5000) begin n_fail++; $display("FAIL wb_issue: got %b/%h want 10/5000", HTRANS, HADDR); end
    next_cycle();
    @(negedge clk_i);
    n_tests++; if (m_hready_o[0] !== 1'b1) begin n_fail++; $display("FAIL wb_done: got %b want 1", m_hready_o[0]); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_priority();
    logic g, prev_g;
    idle_inputs();
    prev_g = 1'b0;
    m_htrans[0] = HTRANS_NONSEQ; m_haddr[0] = 32'h6000;
    m_htrans[1] = HTRANS_NONSEQ; m_haddr[1] = 32'h7000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      g = (HADDR == 32'h7000);
      n_tests++; if (HTRANS !== HTRANS_NONSEQ) begin n_fail++; $display("FAIL pri_busy[%0d]: got %b want 10", i, HTRANS); end
`ifdef URV_DBUS_RR_EN
      if (i > 0) begin
        n_tests++; if (g === prev_g) begin n_fail++; $display("FAIL rr_alt[%0d]: got port %0d want port %0d", i, g, !prev_g); end
      end
`else
      n_tests++; if (g !== 1'b0) begin n_fail++; $display("FAIL pri_fixed[%0d]: got port %0d want port 0", i, g); end
`endif
      prev_g = g;
      next_cycle();
    end
    m_htrans[0] = HTRANS_IDLE; m_htrans[1] = HTRANS_IDLE;
`ifndef URV_DBUS_RR_EN
    @(negedge clk_i);
    n_tests++; if (HADDR !== 32'h7000 || HTRANS !== HTRANS_NONSEQ) begin n_fail++; $display("FAIL pri_drain: got %h/%b want 7000/10", HADDR, HTRANS); end
`endif
    for (int i = 0; i < 4; i++) next_cycle();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    m_htrans[0] = HTRANS_NONSEQ; m_haddr[0] = 32'h8000;
    m_htrans[1] = HTRANS_NONSEQ; m_haddr[1] = 32'h9000;
    next_cycle();
    m_htrans[0] = HTRANS_IDLE; m_htrans[1] = HTRANS_IDLE;
    rst_i = 1'b1;
    @(negedge clk_i);
    n_tests++; if (HTRANS !== HTRANS_IDLE) begin n_fail++; $display("FAIL rm_htrans: got %b want 00", HTRANS); end
    n_tests++; if (m_hready_o !== 2'b11) begin n_fail++; $display("FAIL rm_hready: got %b want 11", m_hready_o); end
    next_cycle();
    rst_i = 1'b0;
    @(negedge clk_i);
    n_tests++; if (HTRANS !== HTRANS_IDLE || HADDR !== 32'h0) begin n_fail++; $display("FAIL rm_noreplay: got %b/%h want 00/0", HTRANS, HADDR); end
    n_tests++; if (m_hready_o !== 2'b11) begin n_fail++; $display("FAIL rm_hready_after: got %b want 11", m_hready_o); end
    next_cycle();
  endtask

  // Masters issue pipelined single transfers, slave inserts random waits; the
  // model checks per-master ordering, payload, write data and read data.
  task automatic test_random();
    localparam int N = 40;
    txn_t pres[2], mdp[2], sdp, t;
    bit   pres_v[2], mdp_v[2], sdp_v;
    int   n_gen[2], n_done[2], cyc, idx;
    txn_t acc_q[$];
    logic [2:0] sizes [3];
    sizes[0] = HSIZE_BYTE; sizes[1] = HSIZE_HALF; sizes[2] = HSIZE_WORD;
    for (int k = 0; k < 2; k++) begin pres_v[k] = 0; mdp_v[k] = 0; n_gen[k] = 0; n_done[k] = 0; end
    sdp_v = 0; cyc = 0;
    idle_inputs();
    rst_i = 1'b1; next_cycle(); rst_i = 1'b0;
    while ((n_done[0] < N || n_done[1] < N) && cyc < 4000) begin
      for (int k = 0; k < 2; k++) begin
        m_htrans[k] = pres_v[k] ? pres[k].trans : HTRANS_IDLE;
        m_haddr[k]  = pres_v[k] ? pres[k].addr : $urandom;
        m_hwrite[k] = pres_v[k] ? pres[k].write : 1'b0;
        m_hsize[k]  = pres_v[k] ? pres[k].size : HSIZE_WORD;
        m_hwdata[k] = mdp_v[k] ? mdp[k].wdata : $urandom;
      end
      HREADY = ($urandom_range(0, 3) != 0);
      HRDATA = sdp_v ? rd_val(sdp.addr) : $urandom;
      HRESP  = 1'b0;
      @(negedge clk_i);
      for (int k = 0; k < 2; k++) begin
        if (m_hready_o[k]) begin
          if (mdp_v[k]) begin
            if (!mdp[k].write) begin
              n_tests++; if (m_hrdata_o[k] !== rd_val(mdp[k].addr)) begin n_fail++; $display("FAIL rnd_rdata m%0d: got %h want %h", k, m_hrdata_o[k], rd_val(mdp[k].addr)); end
            end
            n_done[k]++; mdp_v[k] = 0;
          end
          if (pres_v[k]) begin
            acc_q.push_back(pres[k]); mdp[k] = pres[k]; mdp_v[k] = 1; pres_v[k] = 0;
          end
          if (n_gen[k] < N && $urandom_range(0, 2) != 0) begin
            t.port  = k[0];
            t.addr  = {k[0], 19'h0, 10'($urandom), 2'b00};
            t.write = 1'($urandom);
            t.size  = sizes[$urandom_range(0, 2)];
            t.wdata = $urandom;
            t.trans = ($urandom_range(0, 1) != 0) ? HTRANS_SEQ : HTRANS_NONSEQ;
            pres[k] = t; pres_v[k] = 1; n_gen[k]++;
          end
        end
      end
      if (HREADY) begin
        if (sdp_v) begin
          if (sdp.write) begin
            n_tests++; if (HWDATA !== sdp.wdata) begin n_fail++; $display("FAIL rnd_wdata: got %h want %h", HWDATA, sdp.wdata); end
          end
          sdp_v = 0;
        end
        if (HTRANS[1]) begin
          idx = -1;
          for (int i = 0; i < acc_q.size(); i++)
            if (idx < 0 && acc_q[i].port == HADDR[31]) idx = i;
          n_tests++;
          if (idx < 0) begin
            n_fail++; $display("FAIL rnd_unexpected: got addr %h want no transfer", HADDR);
          end else begin
            t = acc_q[idx]; acc_q.delete(idx);
            if (HADDR !== t.addr || HWRITE !== t.write || HSIZE !== t.size) begin
              n_fail++; $display("FAIL rnd_addr: got %h/%b/%h want %h/%b/%h", HADDR, HWRITE, HSIZE, t.addr, t.write, t.size);
            end
            sdp = t; sdp_v = 1;
          end
        end
      end else begin
        n_tests++; if (HTRANS !== HTRANS_IDLE) begin n_fail++; $display("FAIL rnd_stall_idle: got %b want 00", HTRANS); end
      end
      next_cycle();
      cyc++;
    end
    n_tests++; if (n_done[0] != N) begin n_fail++; $display("FAIL rnd_done_m0: got %0d want %0d", n_done[0], N); end
    n_tests++; if (n_done[1] != N) begin n_fail++; $display("FAIL rnd_done_m1: got %0d want %0d", n_done[1], N); end
    n_tests++; if (acc_q.size() != 0) begin n_fail++; $display("FAIL rnd_leftover: got %0d want 0", acc_q.size()); end
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_conflict();
    test_write_wait();
    test_wait_buffer();
    test_priority();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
